// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared defaults, pixel type and fetch FSM encoding for the TFT pixel path
package tft_pkg;

    localparam int TFT_H_ACTIVE = 800;
    localparam int TFT_V_ACTIVE = 480;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count and clear
module fetch_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign w_rd = i_pop && (r_count != '0);
    assign w_wr = i_push && ((r_count != (AW+1)'(DEPTH)) || w_rd);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/tft_pixel_fetch.sv
// rtl/tft_pixel_fetch.sv - framebuffer prefetcher feeding the TFT timing driver; TFT_FETCH_UFL_CNT_EN adds ufl_count
module tft_pixel_fetch
    import tft_pkg::*;
#(
    parameter int          H_ACTIVE      = TFT_H_ACTIVE,
    parameter int          V_ACTIVE      = TFT_V_ACTIVE,
    parameter int          FIFO_DEPTH    = 64,
    parameter int          ADDR_W        = 19,
    parameter int          BASE_ADDR     = 0,
    parameter logic [15:0] UNDERFLOW_RGB = 16'h0000
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [15:0]       pix_rgb,
    output logic              underflow,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
`ifdef TFT_FETCH_UFL_CNT_EN
    output logic [15:0]       ufl_count,
`endif
    input  logic [15:0]       mem_rdata
);

    localparam int                CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + H_ACTIVE * V_ACTIVE - 1);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_debt;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop;
    logic [15:0]       r_pix_rgb;
    logic              r_ufl;

    rgb565_t           w_head;
    logic [CW-1:0]     w_fifo_count;
    logic [CW:0]       w_credit;
    logic [CW-1:0]     w_inflight_nxt;
    logic [CW-1:0]     w_drop_nxt;
    logic [ADDR_W-1:0] w_debt_nxt;
    logic              w_fire;
    logic              w_drop_ret;
    logic              w_debt_ret;
    logic              w_push;
    logic              w_pop;
    logic              w_empty_pop;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .i_clk   (clk_pix),
        .i_rst   (rst),
        .i_clr   (frame_start),
        .i_push  (w_push),
        .i_data  (mem_rdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    // Every read in flight owns a FIFO slot, so a return can never find the FIFO full.
    assign w_credit = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign mem_req  = (r_state == ST_FETCH) && (w_credit < (CW+1)'(FIFO_DEPTH));
    assign w_fire   = mem_req && mem_gnt;

    assign w_drop_ret     = mem_rvalid && (r_drop != '0);
    assign w_debt_ret     = mem_rvalid && (r_drop == '0) && (r_debt != '0);
    assign w_push         = mem_rvalid && !frame_start && (r_drop == '0) && (r_debt == '0);
    assign w_pop          = pix_pop && (w_fifo_count != '0);
    assign w_empty_pop    = pix_pop && (w_fifo_count == '0);
    assign w_inflight_nxt = r_inflight + CW'(w_fire) - CW'(mem_rvalid);
    assign w_drop_nxt     = r_drop - CW'(w_drop_ret);

    always_comb begin
        w_debt_nxt = r_debt;
        if (w_debt_ret && !w_empty_pop)
            w_debt_nxt = r_debt - 1'b1;
        else if (w_empty_pop && !w_debt_ret && (r_debt != '1))
            w_debt_nxt = r_debt + 1'b1;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= BASE;
            r_debt     <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_pix_rgb  <= UNDERFLOW_RGB;
            r_ufl      <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (pix_pop) r_pix_rgb <= w_pop ? w_head : UNDERFLOW_RGB;
            if (frame_start) begin
                r_addr  <= BASE;
                r_debt  <= '0;
                r_ufl   <= 1'b0;
                r_drop  <= w_inflight_nxt;
                r_state <= (w_inflight_nxt != '0) ? ST_FLUSH : ST_FETCH;
            end else begin
                r_debt <= w_debt_nxt;
                r_drop <= w_drop_nxt;
                if (w_empty_pop) r_ufl <= 1'b1;
                if (w_fire) r_addr <= r_addr + 1'b1;
                case (r_state)
                    ST_FLUSH: if (w_drop_nxt == '0) r_state <= ST_FETCH;
                    ST_FETCH: if (w_fire && (r_addr == LAST)) r_state <= ST_DONE;
                    default:  ;
                endcase
            end
        end
    end

    assign pix_rgb   = r_pix_rgb;
    assign underflow = r_ufl;
    assign mem_addr  = r_addr;

`ifdef TFT_FETCH_UFL_CNT_EN
    logic [15:0] r_ufl_count;

    always_ff @(posedge clk_pix) begin
        if (rst || frame_start)
            r_ufl_count <= '0;
        else if (w_empty_pop && (r_ufl_count != 16'hFFFF))
            r_ufl_count <= r_ufl_count + 1'b1;
    end

    assign ufl_count = r_ufl_count;
`endif

endmodule

// File: tb/tb_tft_pixel_fetch.sv
// tb/tb_tft_pixel_fetch.sv - randomized bench for tft_pixel_fetch against a queue-based reference model
module tb_tft_pixel_fetch;

    localparam int          H     = 40;
    localparam int          V     = 24;
    localparam int          TOTAL = H * V;
    localparam int          DEPTH = 64;
    localparam int          AW    = 19;
    localparam int          BASE  = 64;
    localparam logic [15:0] UFL   = 16'hF81F;
    localparam int          P_IDLE = 0, P_FLUSH = 1, P_FETCH = 2, P_DONE = 3;

    logic          clk_pix = 1'b0;
    logic          rst, frame_start, pix_pop, mem_gnt, mem_rvalid;
    logic [15:0]   mem_rdata, pix_rgb;
    logic          underflow, mem_req;
    logic [AW-1:0] mem_addr;
`ifdef TFT_FETCH_UFL_CNT_EN
    logic [15:0]   ufl_count;
`endif

    always #5 clk_pix = ~clk_pix;

    tft_pixel_fetch #(
        .H_ACTIVE      (H),
        .V_ACTIVE      (V),
        .FIFO_DEPTH    (DEPTH),
        .ADDR_W        (AW),
        .BASE_ADDR     (BASE),
        .UNDERFLOW_RGB (UFL)
    ) dut (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_pop     (pix_pop),
        .pix_rgb     (pix_rgb),
        .underflow   (underflow),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
`ifdef TFT_FETCH_UFL_CNT_EN
        .ufl_count   (ufl_count),
`endif
        .mem_rdata   (mem_rdata)
    );

    int n_checks = 0, n_fail = 0, cyc = 0;
    int gnt_pct = 100, lat_min = 3, lat_max = 3, last_due = 0, guard;
    bit gnt_en = 1'b1;
    int mq_addr[$];
    int mq_due[$];

    logic [15:0] m_fifo[$];
    logic [15:0] m_rgb;
    logic        m_ufl;
    int          m_inflight, m_drop, m_debt, m_phase, m_next, m_uflc, gcount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete(); mq_addr.delete(); mq_due.delete();
        m_rgb = UFL; m_ufl = 1'b0; m_inflight = 0; m_drop = 0; m_debt = 0;
        m_phase = P_IDLE; m_next = BASE; m_uflc = 0; gcount = 0; last_due = 0;
    endtask

    // Predicts the effect of the coming clock edge from the inputs just driven.
    task automatic model_step();
        bit fire, ret, do_push, dec, inc;
        logic [15:0] rd;
        if (rst) begin
            model_reset();
            return;
        end
        fire = mem_req && mem_gnt;
        ret  = mem_rvalid;
        rd   = mem_rdata;
        if (mem_req) begin
            check("req_phase", 32'(m_phase), P_FETCH);
            check("req_credit", 32'(m_fifo.size() + m_inflight < DEPTH), 1);
            check("req_addr", 32'(mem_addr), m_next);
        end
        if (ret) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (fire) begin
            int d;
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(int'(mem_addr));
            mq_due.push_back(d);
            gcount++;
        end
        m_inflight += int'(fire) - int'(ret);
        if (frame_start) begin
            m_fifo.delete();
            m_drop = m_inflight; m_debt = 0; m_ufl = 1'b0; m_uflc = 0;
            m_next = BASE; gcount = 0;
            m_phase = (m_drop > 0) ? P_FLUSH : P_FETCH;
        end else begin
            do_push = 0; dec = 0; inc = 0;
            if (ret) begin
                if (m_drop > 0) m_drop--;
                else if (m_debt > 0) dec = 1;
                else do_push = 1;
            end
            if (pix_pop) begin
                if (m_fifo.size() > 0) m_rgb = m_fifo.pop_front();
                else begin
                    m_rgb = UFL; m_ufl = 1'b1; inc = 1;
                    if (m_uflc < 65535) m_uflc++;
                end
            end
            if (do_push) m_fifo.push_back(rd);
            m_debt = m_debt + int'(inc) - int'(dec);
            if (fire) begin
                m_next++;
                if (m_next == BASE + TOTAL) m_phase = P_DONE;
            end
            if (m_phase == P_FLUSH && m_drop == 0) m_phase = P_FETCH;
        end
    endtask

    task automatic tick();
        mem_gnt = gnt_en && ($urandom_range(99) < gnt_pct);
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'(mq_addr[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        model_step();
        @(posedge clk_pix);
        #1;
        cyc++;
        check("pix_rgb", 32'(pix_rgb), 32'(m_rgb));
        check("underflow", 32'(underflow), 32'(m_ufl));
`ifdef TFT_FETCH_UFL_CNT_EN
        check("ufl_count", 32'(ufl_count), m_uflc);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_pop = 1'b0; frame_start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1; pix_pop = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_rgb", 32'(pix_rgb), 32'(UFL));
        check("rst_ufl", 32'(underflow), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), BASE);
`ifdef TFT_FETCH_UFL_CNT_EN
        check("rst_uflc", 32'(ufl_count), 0);
`endif

        // Fixed latency 3, no pops: prefetch stops at exactly one FIFO's worth.
        start_frame();
        repeat (120) tick();
        check("t1_grants", gcount, DEPTH);
        check("t1_req_off", 32'(mem_req), 0);

        // Zero-wait memory, continuous pops from cycle 80.
        do_reset(); lat_min = 1; lat_max = 1;
        start_frame();
        repeat (79) tick();
        for (int i = 0; i < 800; i++) begin
            pix_pop = 1'b1;
            tick();
            check("t2_px", 32'(pix_rgb), BASE + i);
        end
        pix_pop = 1'b0;
        check("t2_ufl", 32'(underflow), 0);

        // Stalled memory: two underflows, then the skipped slots are discarded.
        do_reset(); gnt_en = 1'b0; lat_min = 3; lat_max = 3;
        start_frame();
        repeat (3) tick();
        pix_pop = 1'b1;
        tick(); check("t3_rgb0", 32'(pix_rgb), 32'(UFL));
        tick(); check("t3_rgb1", 32'(pix_rgb), 32'(UFL));
        pix_pop = 1'b0;
        check("t3_ufl", 32'(underflow), 1);
`ifdef TFT_FETCH_UFL_CNT_EN
        check("t3_uflc", 32'(ufl_count), 2);
`endif
        gnt_en = 1'b1;
        repeat (30) tick();
        pix_pop = 1'b1; tick(); pix_pop = 1'b0;
        check("t3_resume", 32'(pix_rgb), BASE + 2);

        // Restart with five reads in flight: their returns must be dropped.
        do_reset(); lat_min = 8; lat_max = 8;
        start_frame();
        guard = 0;
        while (mq_addr.size() < 5 && guard < 50) begin tick(); guard++; end
        check("t4_inflight", mq_addr.size(), 5);
        gnt_en = 1'b0;
        start_frame();
        gnt_en = 1'b1; lat_min = 3; lat_max = 3;
        repeat (40) tick();
        pix_pop = 1'b1; tick(); pix_pop = 1'b0;
        check("t4_first", 32'(pix_rgb), BASE);

        // Two full frames with a random memory; DONE holds off requests until restart.
        do_reset(); gnt_pct = 70; lat_min = 1; lat_max = 4;
        start_frame();
        for (int f = 0; f < 2; f++) begin
            guard = 0;
            while (gcount < TOTAL && guard < 20000) begin
                pix_pop = ($urandom_range(9) < 8);
                tick();
                guard++;
            end
            pix_pop = 1'b0;
            check("t5_grants", gcount, TOTAL);
            repeat (10) begin
                tick();
                check("t5_done_req", 32'(mem_req), 0);
            end
            if (f == 0) begin
                start_frame();
                repeat (20) tick();
                check("t5_refetch", 32'(gcount > 0), 1);
            end
        end

        // Reset in the middle of a frame with the FIFO partly filled.
        do_reset(); gnt_pct = 100; lat_min = 3; lat_max = 3;
        start_frame();
        pix_pop = 1'b1; tick(); pix_pop = 1'b0;
        repeat (20) tick();
        pix_pop = 1'b1; tick(); pix_pop = 1'b0;
        check("t6_px", 32'(pix_rgb), BASE + 1);
        repeat (14) tick();
        rst = 1'b1; tick();
        check("t6_rgb", 32'(pix_rgb), 32'(UFL));
        check("t6_ufl", 32'(underflow), 0);
        check("t6_req", 32'(mem_req), 0);
        check("t6_addr", 32'(mem_addr), BASE);
        rst = 1'b0;
        repeat (5) tick();
        check("t6_idle_req", 32'(mem_req), 0);

        // Free-running random traffic with occasional restarts and one reset.
        start_frame();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                gnt_pct = int'($urandom_range(100, 20));
                lat_min = 1;
                lat_max = int'($urandom_range(6, 1));
            end
            if (i == 1500) begin
                do_reset();
                start_frame();
            end else if ($urandom_range(399) == 0) begin
                start_frame();
            end else begin
                pix_pop = ($urandom_range(99) < 60);
                tick();
            end
        end
        pix_pop = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
